// File: rtl/scanline_shader.sv
// Scanline shader: darkens every odd output line of the doubled video stream by a frame-latched amount.
// Two ce_pix pipeline stages; rgb, syncs, blanks and line parity all leave with identical latency.
module scanline_shader #(
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [1:0]    scanlines,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hb_in,
    input  logic          vb_in,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    output logic          hs_out,
    output logic          vs_out,
    output logic          hb_out,
    output logic          vb_out,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          line_odd
);

    logic                 hs_d, vs_d;
    logic                 parity;
    logic [1:0]           mode;

    logic                 hs_fall, vs_rise;
    logic                 parity_next;
    logic [1:0]           mode_next;

    logic [2:0][DW-1:0]   in_c;
    logic [2:0][DW-1:0]   s1_c, s1_h, s1_q;
    logic                 s1_hs, s1_vs, s1_hb, s1_vb;
    logic                 s1_blank, s1_dark, s1_odd;
    logic [1:0]           s1_mode;

    logic [2:0][DW-1:0]   out_c;
    logic [2:0][DW-1:0]   shaded;

    assign in_c = {b_in, g_in, r_in};

    // Edge events of this ce; a vsync rise overrides a coincident hsync fall so the new frame starts even.
    always_comb begin
        hs_fall     = hs_d & ~hs_in;
        vs_rise     = ~vs_d & vs_in;
        parity_next = parity;
        mode_next   = mode;
        if (vs_rise) begin
            parity_next = 1'b0;
            mode_next   = scanlines;
        end else if (hs_fall) begin
            parity_next = ~parity;
        end
    end

    function automatic logic [DW-1:0] shade(input logic [DW-1:0] c,
                                            input logic [DW-1:0] ch,
                                            input logic [DW-1:0] cq,
                                            input logic          blank,
                                            input logic          dark,
                                            input logic [1:0]    m);
        shade = c;
        if (blank) begin
            shade = '0;
        end else if (dark) begin
            case (m)
                2'd1:    shade = c - cq;
                2'd2:    shade = ch;
                2'd3:    shade = cq;
                default: shade = c;
            endcase
        end
    endfunction

    always_comb begin
        shaded = '0;
        for (int i = 0; i < 3; i++) begin
            shaded[i] = shade(s1_c[i], s1_h[i], s1_q[i], s1_blank, s1_dark, s1_mode);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            parity   <= 1'b0;
            mode     <= 2'd0;
            s1_c     <= '0;
            s1_h     <= '0;
            s1_q     <= '0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hb    <= 1'b0;
            s1_vb    <= 1'b0;
            s1_blank <= 1'b0;
            s1_dark  <= 1'b0;
            s1_odd   <= 1'b0;
            s1_mode  <= 2'd0;
            out_c    <= '0;
            hs_out   <= 1'b0;
            vs_out   <= 1'b0;
            hb_out   <= 1'b0;
            vb_out   <= 1'b0;
            line_odd <= 1'b0;
        end else if (ce_pix) begin
            hs_d     <= hs_in;
            vs_d     <= vs_in;
            parity   <= parity_next;
            mode     <= mode_next;

            for (int i = 0; i < 3; i++) begin
                s1_c[i] <= in_c[i];
                s1_h[i] <= in_c[i] >> 1;
                s1_q[i] <= in_c[i] >> 2;
            end
            s1_hs    <= hs_in;
            s1_vs    <= vs_in;
            s1_hb    <= hb_in;
            s1_vb    <= vb_in;
            s1_blank <= hb_in | vb_in;
            s1_dark  <= parity_next & (mode_next != 2'd0);
            s1_odd   <= parity_next;
            s1_mode  <= mode_next;

            out_c    <= shaded;
            hs_out   <= s1_hs;
            vs_out   <= s1_vs;
            hb_out   <= s1_hb;
            vb_out   <= s1_vb;
            line_odd <= s1_odd;
        end
    end

    assign r_out = out_c[0];
    assign g_out = out_c[1];
    assign b_out = out_c[2];

endmodule

// File: tb/tb_scanline_shader.sv
// Directed bench for scanline_shader: each driven pixel pushes its hand-computed output into exp_q,
// which is popped one ce later, so every output is checked exactly two ce after its input.
module tb_scanline_shader;

    localparam int DW = 8;
    localparam int PW = 5 + 3 * DW;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_pix  = 1'b0;
    logic [1:0]    scanlines = 2'd0;
    logic          hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
    logic [DW-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic          hs_out, vs_out, hb_out, vb_out, line_odd;
    logic [DW-1:0] r_out, g_out, b_out;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_exp;
    logic          gap = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    mode_exp [4];

    scanline_shader #(.DW(DW)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce_pix   (ce_pix),
        .scanlines(scanlines),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .hb_in    (hb_in),
        .vb_in    (vb_in),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .hb_out   (hb_out),
        .vb_out   (vb_out),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out),
        .line_odd (line_odd)
    );

    always #5 clk_sys = ~clk_sys;

    // {hs, vs, hb, vb, line_odd, r, g, b}
    function automatic logic [PW-1:0] out_pack();
        return {hs_out, vs_out, hb_out, vb_out, line_odd, r_out, g_out, b_out};
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (hs,vs,hb,vb,odd,rgb) expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic restart_queue();
        exp_q.delete();
        exp_q.push_back('0);
        last_exp = '0;
    endtask

    // One ce pixel; with gap set, two idle cycles with scrambled inputs precede it and must not move the outputs.
    task automatic pix(input string tag, input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb, input logic eodd);
        if (gap) begin
            for (int i = 0; i < 2; i++) begin
                ce_pix = 1'b0;
                hs_in  = 1'($urandom_range(0, 1));
                vs_in  = 1'($urandom_range(0, 1));
                r_in   = 8'($urandom_range(0, 255));
                @(posedge clk_sys); #1;
                check({tag, "_hold"}, out_pack(), last_exp);
            end
        end
        ce_pix = 1'b1;
        hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
        exp_q.push_back({hs, vs, hb, vb, eodd, er, eg, eb});
        @(posedge clk_sys); #1;
        ce_pix = 1'b0;
        last_exp = exp_q.pop_front();
        check(tag, out_pack(), last_exp);
    endtask

    task automatic hsync(input logic [7:0] c, input logic odd_prev);
        pix("hsync", 1'b1, 1'b0, 1'b1, 1'b0, c, c, c, 8'h00, 8'h00, 8'h00, odd_prev);
        pix("hsync", 1'b1, 1'b0, 1'b1, 1'b0, c, c, c, 8'h00, 8'h00, 8'h00, odd_prev);
    endtask

    // hsync falls on the same ce that vsync rises: the frame must start on an even line.
    task automatic vstart(input logic [7:0] c, input logic odd_prev);
        pix("vstart", 1'b1, 1'b0, 1'b1, 1'b0, c, c, c, 8'h00, 8'h00, 8'h00, odd_prev);
        pix("vstart", 1'b0, 1'b1, 1'b0, 1'b1, c, c, c, 8'h00, 8'h00, 8'h00, 1'b0);
        pix("vstart", 1'b0, 1'b1, 1'b0, 1'b1, c, c, c, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic active(input string tag, input logic [7:0] c, input logic [7:0] e, input logic odd);
        for (int i = 0; i < 3; i++) begin
            pix(tag, 1'b0, 1'b0, 1'b0, 1'b0, c, c, c, e, e, e, odd);
        end
    endtask

    initial begin
        mode_exp[0] = 8'hC8;
        mode_exp[1] = 8'h96;
        mode_exp[2] = 8'h64;
        mode_exp[3] = 8'h32;

        // Reset held with random inputs: outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            ce_pix    = 1'($urandom_range(0, 1));
            scanlines = 2'($urandom_range(0, 3));
            hs_in = 1'($urandom_range(0, 1)); vs_in = 1'($urandom_range(0, 1));
            hb_in = 1'($urandom_range(0, 1)); vb_in = 1'($urandom_range(0, 1));
            r_in = 8'($urandom_range(0, 255)); g_in = 8'($urandom_range(0, 255));
            b_in = 8'($urandom_range(0, 255));
            @(posedge clk_sys); #1;
            check("reset", out_pack(), '0);
        end
        ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        reset_n = 1'b1;
        restart_queue();

        // Mode stays off until the first vsync rise even with scanlines=2.
        scanlines = 2'd2;
        hsync(8'hFF, 1'b0);
        active("mode_off_odd", 8'hFF, 8'hFF, 1'b1);

        // 50% scanlines, four lines.
        vstart(8'hFF, 1'b1);
        active("m2_line0", 8'hFF, 8'hFF, 1'b0);
        hsync(8'hFF, 1'b0);
        active("m2_line1", 8'hFF, 8'h7F, 1'b1);
        hsync(8'hFF, 1'b1);
        active("m2_line2", 8'hFF, 8'hFF, 1'b0);
        hsync(8'hFF, 1'b0);
        active("m2_line3", 8'hFF, 8'h7F, 1'b1);

        // Each mode on an odd line with input C8.
        for (int m = 1; m <= 4; m++) begin
            scanlines = 2'(m % 4);
            vstart(8'hC8, 1'b1);
            active("modes_even", 8'hC8, 8'hC8, 1'b0);
            hsync(8'hC8, 1'b0);
            active("modes_odd", 8'hC8, mode_exp[m % 4], 1'b1);
        end

        // Frame-latched mode: 1 -> 3 mid-frame only applies after the next vsync rise.
        scanlines = 2'd1;
        vstart(8'hC8, 1'b1);
        active("latch_l0", 8'hC8, 8'hC8, 1'b0);
        scanlines = 2'd3;
        hsync(8'hC8, 1'b0);
        active("latch_l1", 8'hC8, 8'h96, 1'b1);
        pix("latch_rgb", 1'b0, 1'b0, 1'b0, 1'b0, 8'hC8, 8'h40, 8'h0F, 8'h96, 8'h30, 8'h0C, 1'b1);
        hsync(8'hC8, 1'b1);
        active("latch_l2", 8'hC8, 8'hC8, 1'b0);
        hsync(8'hC8, 1'b0);
        active("latch_l3", 8'hC8, 8'h96, 1'b1);
        vstart(8'hC8, 1'b1);
        active("latch_next_l0", 8'hC8, 8'hC8, 1'b0);
        hsync(8'hC8, 1'b0);
        active("latch_next_l1", 8'hC8, 8'h32, 1'b1);

        // Blanking with bright input, hb and vb separately and together.
        pix("hblank", 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
        pix("vblank", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
        pix("hvblank", 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);

        // Gapped ce (1 of 3) with the coincident hsync fall / vsync rise.
        scanlines = 2'd2;
        gap = 1'b1;
        vstart(8'hFF, 1'b1);
        active("gap_l0", 8'hFF, 8'hFF, 1'b0);
        hsync(8'hFF, 1'b0);
        active("gap_l1", 8'hFF, 8'h7F, 1'b1);
        gap = 1'b0;

        // Asynchronous reset mid-line: outputs clear without a clock edge; parity and mode restart.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", out_pack(), '0);
        @(posedge clk_sys); #1;
        check("async_reset_held", out_pack(), '0);
        hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
        reset_n = 1'b1;
        restart_queue();
        hsync(8'hFF, 1'b0);
        active("post_reset_off", 8'hFF, 8'hFF, 1'b1);
        vstart(8'hFF, 1'b1);
        active("post_reset_l0", 8'hFF, 8'hFF, 1'b0);
        hsync(8'hFF, 1'b0);
        active("post_reset_l1", 8'hFF, 8'h7F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
